dir_input_queue: RTL
====================

DIR_INPUT_QUEUE -- requirements
Module: dir_input_queue

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, the number of stable-low clk cycles before a key counts as pressed (5 ms at 50 MHz).
REQ-002 Parameter QUEUE_DEPTH, default 4, the number of pending turn requests held; it SHALL be a power of two, 2..16.
REQ-003 Port clk, input, 1, the 50 MHz system clock.
REQ-004 Port resetn, input, 1, reset; asynchronous, active-low.
REQ-005 Port key_n, input, 4, raw active-low push buttons: [2]=UP, [3]=LEFT, [1]=DOWN, [0]=RIGHT.
REQ-006 Port move_tick, input, 1, a one-cycle pulse issued by the game datapath on every snake step.
REQ-007 Port game_start, input, 1, a one-cycle synchronous pulse that flushes state for a new game.
REQ-008 Port direction, output, 5, the registered one-hot current heading: UP=00010, LEFT=00100, DOWN=01000, RIGHT=10000.
REQ-009 Port q_count, output, $clog2(QUEUE_DEPTH)+1, the number of queued requests.
REQ-010 Port overflow, output, 1, a sticky flag set when a valid request is dropped because the queue is full.

Function
REQ-011 Each key_n bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 The debounced state SHALL go to "pressed" after DEBOUNCE_CYCLES consecutive synchronized-low cycles and to "released" after DEBOUNCE_CYCLES consecutive synchronized-high cycles; any change of value restarts the counter.
REQ-013 A press event SHALL be a one-cycle pulse on the released-to-pressed transition only; holding a key SHALL produce no further events.
REQ-014 When press events for several keys occur in the same cycle, only one SHALL be taken, in priority order UP > LEFT > DOWN > RIGHT; the others are discarded.
REQ-015 The reference heading SHALL be the queue tail entry when q_count>0, and direction otherwise.
REQ-016 An event SHALL be discarded if it equals the reference heading or is its reverse (UP/DOWN, LEFT/RIGHT); otherwise it SHALL be pushed.
REQ-017 A push when q_count==QUEUE_DEPTH and no pop occurs in the same cycle SHALL be dropped and SHALL set overflow.
REQ-018 On move_tick with q_count>0, the head entry SHALL be popped and loaded into direction on the next clock edge (1-cycle latency).
REQ-019 On move_tick with an empty queue, direction SHALL hold.
REQ-020 A push and a pop in the same cycle SHALL both complete, leaving q_count unchanged; a push is accepted when full if a pop occurs in that cycle.
REQ-021 A push into an empty queue SHALL NOT bypass to direction in the same cycle; it waits for the next move_tick.
REQ-022 Read and write pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-023 game_start SHALL take priority over push and pop in the same cycle: the queue empties, direction becomes RIGHT, and overflow clears. Debounce state SHALL be preserved.
REQ-024 direction SHALL always be exactly one-hot.

Reset
REQ-025 While resetn is low: direction=10000, q_count=0, overflow=0, pointers=0, all debounced states "released", all counters 0, synchronizer flops 1.
REQ-026 Reset assertion mid-debounce or mid-queue SHALL discard all pending state immediately.

Configuration
REQ-027 Macro SNAKE_DIR_DEBOUNCE_EN: when defined, debouncing follows REQ-012; when undefined, the synchronized key value is used directly as the debounced state, so press events follow the synchronizer with no counter. This is the fast-simulation build.

Structure
REQ-028 Package snake_pkg SHALL hold the direction encodings DIR_UP, DIR_LEFT, DIR_DOWN and DIR_RIGHT, the is-reverse function, and the default heading constant; the game datapath SHALL use the same package.
REQ-029 One sub-module, key_debounce (synchronizer, counter and edge pulse for a single key), SHALL be instantiated four times.

Verification
REQ-030 Press UP (hold 300000 cycles), then move_tick -> q_count 1 then 0, direction=00010 one cycle after the tick.
REQ-031 Glitch: key_n[0] low for 1000 cycles then high -> no event, q_count stays 0.
REQ-032 Heading RIGHT, press LEFT, then RIGHT, then DOWN -> LEFT and RIGHT dropped, only DOWN queued (q_count=1).
REQ-033 Queue UP, LEFT, DOWN, RIGHT alternately, then a fifth valid press with no tick -> q_count=4, overflow=1; four ticks pop in order UP, LEFT, DOWN, RIGHT.
REQ-034 Full queue, with a valid press and move_tick in the same cycle -> q_count stays 4 and overflow stays 0.
REQ-035 Two entries queued, then game_start coincident with move_tick -> q_count=0 and direction=10000; also, resetn low mid-debounce -> outputs at their reset values asynchronously.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake game definitions: one-hot heading encodings, default heading,
// key bit positions and the reverse-heading helper.
package snake_pkg;

   typedef enum logic [4:0] {
      DIR_UP    = 5'b00010,
      DIR_LEFT  = 5'b00100,
      DIR_DOWN  = 5'b01000,
      DIR_RIGHT = 5'b10000
   } dir_t;

   localparam dir_t DIR_DEFAULT = DIR_RIGHT;

   // Bit positions of each button within the raw key_n bus
   localparam int KEY_RIGHT = 0;
   localparam int KEY_DOWN  = 1;
   localparam int KEY_UP    = 2;
   localparam int KEY_LEFT  = 3;

   function automatic logic is_reverse(input dir_t a, input dir_t b);
      return ((a == DIR_UP)    && (b == DIR_DOWN))  ||
             ((a == DIR_DOWN)  && (b == DIR_UP))    ||
             ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
             ((a == DIR_RIGHT) && (b == DIR_LEFT));
   endfunction

endpackage

// File: rtl/dir_input_queue_if.sv
// Bus between the direction input queue and the game datapath:
// raw keys and game pulses in, heading and queue status out.
interface dir_input_queue_if
   import snake_pkg::*;
#(
   parameter int QUEUE_DEPTH = 4
);
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   logic [3:0]    key_n;
   logic          move_tick;
   logic          game_start;
   dir_t          direction;
   logic [CW-1:0] q_count;
   logic          overflow;

   modport master (
      output key_n, move_tick, game_start,
      input  direction, q_count, overflow
   );

   modport slave (
      input  key_n, move_tick, game_start,
      output direction, q_count, overflow
   );
endinterface

// File: rtl/key_debounce.sv
// One push button: 2-flop synchronizer, optional debounce counter
// (SNAKE_DIR_DEBOUNCE_EN) and a single-cycle press pulse.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic resetn,
   input  logic key_n,
   output logic press
);

   logic [1:0] sync;
   logic       pressed;
   logic       pressed_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], key_n};
      end
   end

`ifdef SNAKE_DIR_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] cnt;
   logic             state;
   logic             differ;

   assign differ = (~sync[1]) != state;

   // Counts consecutive cycles that disagree with the debounced state; any
   // return to agreement restarts the count.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt   <= '0;
         state <= 1'b0;
      end else if (!differ) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         cnt   <= '0;
         state <= ~state;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign pressed = state;
`else
   logic unused_cfg;

   assign unused_cfg = ^DEBOUNCE_CYCLES;
   assign pressed    = ~sync[1];
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pressed_q <= 1'b0;
      end else begin
         pressed_q <= pressed;
      end
   end

   assign press = pressed & ~pressed_q;

endmodule

// File: rtl/dir_input_queue.sv
// Snake turn-request queue: debounced key presses are filtered against the
// latest heading and buffered until move_tick. Debounce enabled by SNAKE_DIR_DEBOUNCE_EN.
module dir_input_queue
   import snake_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int QUEUE_DEPTH     = 4
) (
   input logic             clk,
   input logic             resetn,
   dir_input_queue_if.slave bus
);

   localparam int            PW   = $clog2(QUEUE_DEPTH);
   localparam int            CW   = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

   logic [3:0]    press;
   logic          ev_valid;
   dir_t          ev_dir;
   dir_t          mem [QUEUE_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   dir_t          dir_q;
   logic          ovf_q;
   dir_t          ref_dir;
   logic          push_req;
   logic          pop;
   logic          push;
   logic          drop;

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
         .clk    (clk),
         .resetn (resetn),
         .key_n  (bus.key_n[k]),
         .press  (press[k])
      );
   end

   // Simultaneous presses resolve to a single event: UP > LEFT > DOWN > RIGHT
   always_comb begin
      ev_valid = |press;
      ev_dir   = DIR_RIGHT;
      if (press[KEY_UP]) begin
         ev_dir = DIR_UP;
      end else if (press[KEY_LEFT]) begin
         ev_dir = DIR_LEFT;
      end else if (press[KEY_DOWN]) begin
         ev_dir = DIR_DOWN;
      end
   end

   // New requests are judged against the newest queued heading, not the live one
   always_comb begin
      ref_dir  = (count != '0) ? mem[wr_ptr - PW'(1)] : dir_q;
      push_req = ev_valid && (ev_dir != ref_dir) && !is_reverse(ev_dir, ref_dir);
      pop      = bus.move_tick && (count != '0);
      push     = push_req && ((count != FULL) || pop);
      drop     = push_req && (count == FULL) && !pop;
   end

   always_ff @(posedge clk) begin
      if (push && !bus.game_start) begin
         mem[wr_ptr] <= ev_dir;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         dir_q  <= DIR_DEFAULT;
         ovf_q  <= 1'b0;
      end else if (bus.game_start) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         dir_q  <= DIR_DEFAULT;
         ovf_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
            dir_q  <= mem[rd_ptr];
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         if (drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign bus.direction = dir_q;
   assign bus.q_count   = count;
   assign bus.overflow  = ovf_q;

endmodule
